mem_port_arbiter: RTL and testbench

//  Shares the single data-memory port (mem) between the Fetch stage (read-only) and the Memory stage (read/write).

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_age_ctr.sv | 38 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and enums for the data-memory port arbiter (mem_port_arbiter).
// Optional starvation guard is selected by MEM_ARB_STARVE_GUARD_EN.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_LINE = 16;
    localparam int unsigned D_SIZE    = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        REQ_F,
        REQ_M
    } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_age_ctr.sv
// Saturating count of back-to-back Memory-stage grants taken while Fetch waits.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_age_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic full_o
);

    localparam int unsigned   AW      = $clog2(LIMIT + 1);
    localparam logic [AW-1:0] LIMIT_V = AW'(LIMIT);

    logic [AW-1:0] age_q;
    logic [AW-1:0] age_d;

    always_comb begin
        age_d = age_q;
        if (clr_i) begin
            age_d = '0;
        end else if (inc_i && (age_q != LIMIT_V)) begin
            age_d = age_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign full_o = (age_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between Fetch (read-only) and Memory stage.
// Define MEM_ARB_STARVE_GUARD_EN to force a Fetch grant after STARVE_LIMIT straight M grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_LINE    = mem_port_arbiter_pkg::ADDR_LINE,
    parameter int unsigned D_SIZE       = mem_port_arbiter_pkg::D_SIZE,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_req,
    input  logic [ADDR_LINE-1:0] f_addr,
    output logic                 f_gnt,
    output logic                 f_rvalid,
    output logic [D_SIZE-1:0]    f_rdata,
    input  logic                 m_req,
    input  logic                 m_rw,
    input  logic [ADDR_LINE-1:0] m_addr,
    input  logic [D_SIZE-1:0]    m_wdata,
    output logic                 m_gnt,
    output logic                 m_rvalid,
    output logic [D_SIZE-1:0]    m_rdata,
    output logic                 stall_f,
    output logic                 stall_m,
    output logic                 mem_update,
    output logic                 mem_rw,
    output logic [ADDR_LINE-1:0] mem_addr,
    output logic [D_SIZE-1:0]    mem_wdata,
    input  logic [D_SIZE-1:0]    mem_rdata
);

    import mem_port_arbiter_pkg::*;

    if (MEM_LAT < 1 || STARVE_LIMIT < 1) begin : g_param_check
        $error("mem_port_arbiter: MEM_LAT and STARVE_LIMIT must be >= 1");
    end

    localparam int unsigned   CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    arb_state_t           state_q, state_d;
    req_id_t              owner_q, owner_d;
    logic                 rw_q, rw_d;
    logic [ADDR_LINE-1:0] addr_q, addr_d;
    logic [D_SIZE-1:0]    wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [D_SIZE-1:0]    f_rdata_q, f_rdata_d;
    logic [D_SIZE-1:0]    m_rdata_q, m_rdata_d;
    logic                 force_f;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic age_inc;
    logic age_clr;
    logic age_full;

    assign age_inc = (state_q == ISSUE) && (owner_q == REQ_M) && f_req;
    assign age_clr = (state_q == ISSUE) && ((owner_q == REQ_F) || !f_req);
    assign force_f = f_req && age_full;

    mem_arb_age_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_age_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (age_inc),
        .clr_i  (age_clr),
        .full_o (age_full)
    );
`else
    assign force_f = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        f_rdata_d  = f_rdata_q;
        m_rdata_d  = m_rdata_q;
        f_gnt      = 1'b0;
        m_gnt      = 1'b0;
        f_rvalid   = 1'b0;
        m_rvalid   = 1'b0;
        mem_update = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (m_req && !force_f) begin
                    owner_d = REQ_M;
                    rw_d    = m_rw;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    state_d = ISSUE;
                end else if (f_req) begin
                    owner_d = REQ_F;
                    rw_d    = 1'b0;
                    addr_d  = f_addr;
                    wdata_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_update = 1'b1;
                mem_rw     = rw_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                f_gnt      = (owner_q == REQ_F);
                m_gnt      = (owner_q == REQ_M);
                cnt_d      = CNT_INIT;
                state_d    = WAIT;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (owner_q == REQ_F) begin
                        f_rvalid  = 1'b1;
                        f_rdata_d = mem_rdata;
                    end else begin
                        m_rvalid = 1'b1;
                        if (!rw_q) begin
                            m_rdata_d = mem_rdata;
                        end
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= REQ_F;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            f_rdata_q <= '0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            f_rdata_q <= f_rdata_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    // Read data is presented in the rvalid cycle itself and held from the register afterwards.
    assign f_rdata = f_rdata_d;
    assign m_rdata = m_rdata_d;

    assign stall_f = f_req & ~f_rvalid;
    assign stall_m = m_req & ~m_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus reset, starvation and MEM_LAT=3 sequences.
// Grant-order expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;

    logic        f_req, m_req, m_rw;
    logic [15:0] f_addr, m_addr;
    logic [31:0] m_wdata;
    logic        f_gnt, f_rvalid, m_gnt, m_rvalid, stall_f, stall_m;
    logic [31:0] f_rdata, m_rdata;
    logic        mem_update, mem_rw;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        f_req3, m_req3, m_rw3;
    logic [15:0] f_addr3, m_addr3;
    logic [31:0] m_wdata3;
    logic        f_gnt3, f_rvalid3, m_gnt3, m_rvalid3, stall_f3, stall_m3;
    logic [31:0] f_rdata3, m_rdata3;
    logic        mem_update3, mem_rw3;
    logic [15:0] mem_addr3;
    logic [31:0] mem_wdata3, mem_rdata3;

    mem_port_arbiter #(
        .ADDR_LINE    (16),
        .D_SIZE       (32),
        .MEM_LAT      (1),
        .STARVE_LIMIT (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .f_rdata    (f_rdata),
        .m_req      (m_req),
        .m_rw       (m_rw),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_gnt      (m_gnt),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata),
        .stall_f    (stall_f),
        .stall_m    (stall_m),
        .mem_update (mem_update),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    mem_port_arbiter #(
        .ADDR_LINE    (16),
        .D_SIZE       (32),
        .MEM_LAT      (3),
        .STARVE_LIMIT (4)
    ) dut3 (
        .clk        (clk),
        .reset      (reset),
        .f_req      (f_req3),
        .f_addr     (f_addr3),
        .f_gnt      (f_gnt3),
        .f_rvalid   (f_rvalid3),
        .f_rdata    (f_rdata3),
        .m_req      (m_req3),
        .m_rw       (m_rw3),
        .m_addr     (m_addr3),
        .m_wdata    (m_wdata3),
        .m_gnt      (m_gnt3),
        .m_rvalid   (m_rvalid3),
        .m_rdata    (m_rdata3),
        .stall_f    (stall_f3),
        .stall_m    (stall_m3),
        .mem_update (mem_update3),
        .mem_rw     (mem_rw3),
        .mem_addr   (mem_addr3),
        .mem_wdata  (mem_wdata3),
        .mem_rdata  (mem_rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data appears MEM_LAT cycles after the update cycle.
    logic [31:0] mem1 [256];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (mem_update) begin
            if (mem_rw) mem1[mem_addr[7:0]] <= mem_wdata;
            else        rd1 <= mem1[mem_addr[7:0]];
        end
    end
    assign mem_rdata = rd1;

    logic [31:0] mem3 [256];
    logic [31:0] s0, s1, s2;
    always @(posedge clk) begin
        if (mem_update3 && !mem_rw3) s0 <= mem3[mem_addr3[7:0]];
        s1 <= s0;
        s2 <= s1;
    end
    assign mem_rdata3 = s2;

    int unsigned n_cmp;
    int unsigned n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        fr;
        logic [15:0] fa;
        logic        mr;
        logic        mrw;
        logic [15:0] ma;
        logic [31:0] mwd;
        logic        fg, fv, mg, mv, upd, rw;
        logic [15:0] addr;
        logic [31:0] wd;
        logic        sf, sm;
        logic [31:0] frd, mrd;
    } vec_t;

    function automatic vec_t mk(
        input logic fr, input logic [15:0] fa, input logic mr, input logic mrw,
        input logic [15:0] ma, input logic [31:0] mwd,
        input logic fg, input logic fv, input logic mg, input logic mv,
        input logic upd, input logic rw, input logic [15:0] addr, input logic [31:0] wd,
        input logic sf, input logic sm, input logic [31:0] frd, input logic [31:0] mrd);
        vec_t v;
        v.fr = fr; v.fa = fa; v.mr = mr; v.mrw = mrw; v.ma = ma; v.mwd = mwd;
        v.fg = fg; v.fv = fv; v.mg = mg; v.mv = mv; v.upd = upd; v.rw = rw;
        v.addr = addr; v.wd = wd; v.sf = sf; v.sm = sm; v.frd = frd; v.mrd = mrd;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t vecs [NV];

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] D3 = 32'h12345678;
    localparam logic [31:0] D4 = 32'hCAFEF00D;
    localparam logic [31:0] A5 = 32'h0000A5A5;

    logic        g    [10];
    logic        expg [10];
    int unsigned ng;
    int unsigned n_exp;
    logic        got;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mem1[8'h10] = DB;
        mem1[8'h30] = D3;
        mem1[8'h44] = D4;
        mem3[8'h44] = 32'h0BADCAFE;
        rd1 = '0; s0 = '0; s1 = '0; s2 = '0;

        //            fr fa     mr rw ma     wdata   fg fv mg mv up rw addr   wdata   sf sm f_rdata m_rdata
        vecs[0]  = mk(1, 16'h10, 0, 0, 16'h0,  32'h0,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   1, 0, 32'h0, 32'h0);
        vecs[1]  = mk(1, 16'h10, 0, 0, 16'h0,  32'h0,   1, 0, 0, 0, 1, 0, 16'h10, 32'h0,   1, 0, 32'h0, 32'h0);
        vecs[2]  = mk(1, 16'h10, 0, 0, 16'h0,  32'h0,   0, 1, 0, 0, 0, 0, 16'h0,  32'h0,   0, 0, DB,    32'h0);
        vecs[3]  = mk(0, 16'h0,  0, 0, 16'h0,  32'h0,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   0, 0, DB,    32'h0);
        vecs[4]  = mk(1, 16'h30, 1, 1, 16'h20, 32'h5,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   1, 1, DB,    32'h0);
        vecs[5]  = mk(1, 16'h30, 1, 1, 16'h20, 32'h5,   0, 0, 1, 0, 1, 1, 16'h20, 32'h5,   1, 1, DB,    32'h0);
        vecs[6]  = mk(1, 16'h30, 0, 0, 16'h0,  32'h0,   0, 0, 0, 1, 0, 0, 16'h0,  32'h0,   1, 0, DB,    32'h0);
        vecs[7]  = mk(1, 16'h30, 0, 0, 16'h0,  32'h0,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   1, 0, DB,    32'h0);
        vecs[8]  = mk(1, 16'h30, 0, 0, 16'h0,  32'h0,   1, 0, 0, 0, 1, 0, 16'h30, 32'h0,   1, 0, DB,    32'h0);
        vecs[9]  = mk(0, 16'h0,  0, 0, 16'h0,  32'h0,   0, 1, 0, 0, 0, 0, 16'h0,  32'h0,   0, 0, D3,    32'h0);
        vecs[10] = mk(0, 16'h0,  1, 1, 16'h20, A5,      0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   0, 1, D3,    32'h0);
        vecs[11] = mk(0, 16'h0,  1, 1, 16'h20, A5,      0, 0, 1, 0, 1, 1, 16'h20, A5,      0, 1, D3,    32'h0);
        vecs[12] = mk(0, 16'h0,  0, 0, 16'h0,  32'h0,   0, 0, 0, 1, 0, 0, 16'h0,  32'h0,   0, 0, D3,    32'h0);
        vecs[13] = mk(0, 16'h0,  1, 0, 16'h20, 32'h0,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   0, 1, D3,    32'h0);
        vecs[14] = mk(0, 16'h0,  1, 0, 16'h20, 32'h0,   0, 0, 1, 0, 1, 0, 16'h20, 32'h0,   0, 1, D3,    32'h0);
        vecs[15] = mk(0, 16'h0,  0, 0, 16'h0,  32'h0,   0, 0, 0, 1, 0, 0, 16'h0,  32'h0,   0, 0, D3,    A5);
        vecs[16] = mk(0, 16'h0,  0, 0, 16'h0,  32'h0,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   0, 0, D3,    A5);
        vecs[17] = mk(1, 16'h40, 1, 0, 16'h44, 32'h0,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   1, 1, D3,    A5);
        vecs[18] = mk(0, 16'h0,  1, 0, 16'h44, 32'h0,   0, 0, 1, 0, 1, 0, 16'h44, 32'h0,   0, 1, D3,    A5);
        vecs[19] = mk(0, 16'h0,  0, 0, 16'h0,  32'h0,   0, 0, 0, 1, 0, 0, 16'h0,  32'h0,   0, 0, D3,    D4);
        vecs[20] = mk(0, 16'h0,  0, 0, 16'h0,  32'h0,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   0, 0, D3,    D4);
        vecs[21] = mk(0, 16'h0,  0, 0, 16'h0,  32'h0,   0, 0, 0, 0, 0, 0, 16'h0,  32'h0,   0, 0, D3,    D4);

        reset = 1'b1;
        f_req = 1'b0; f_addr = '0; m_req = 1'b0; m_rw = 1'b0; m_addr = '0; m_wdata = '0;
        f_req3 = 1'b0; f_addr3 = '0; m_req3 = 1'b0; m_rw3 = 1'b0; m_addr3 = '0; m_wdata3 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.f_gnt",      32'(f_gnt),      32'h0);
        chk("reset.m_gnt",      32'(m_gnt),      32'h0);
        chk("reset.mem_update", 32'(mem_update), 32'h0);
        chk("reset.mem_addr",   32'(mem_addr),   32'h0);
        chk("reset.f_rdata",    f_rdata,         32'h0);
        chk("reset.m_rdata",    m_rdata,         32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            f_req = vecs[i].fr; f_addr = vecs[i].fa;
            m_req = vecs[i].mr; m_rw = vecs[i].mrw; m_addr = vecs[i].ma; m_wdata = vecs[i].mwd;
            #1;
            chk($sformatf("v%0d.f_gnt", i),      32'(f_gnt),      32'(vecs[i].fg));
            chk($sformatf("v%0d.f_rvalid", i),   32'(f_rvalid),   32'(vecs[i].fv));
            chk($sformatf("v%0d.m_gnt", i),      32'(m_gnt),      32'(vecs[i].mg));
            chk($sformatf("v%0d.m_rvalid", i),   32'(m_rvalid),   32'(vecs[i].mv));
            chk($sformatf("v%0d.mem_update", i), 32'(mem_update), 32'(vecs[i].upd));
            chk($sformatf("v%0d.mem_rw", i),     32'(mem_rw),     32'(vecs[i].rw));
            chk($sformatf("v%0d.mem_addr", i),   32'(mem_addr),   32'(vecs[i].addr));
            chk($sformatf("v%0d.mem_wdata", i),  mem_wdata,       vecs[i].wd);
            chk($sformatf("v%0d.stall_f", i),    32'(stall_f),    32'(vecs[i].sf));
            chk($sformatf("v%0d.stall_m", i),    32'(stall_m),    32'(vecs[i].sm));
            chk($sformatf("v%0d.f_rdata", i),    f_rdata,         vecs[i].frd);
            chk($sformatf("v%0d.m_rdata", i),    m_rdata,         vecs[i].mrd);
            @(posedge clk);
            #1;
        end

        // Reset while the fetch access sits in WAIT.
        f_req = 1'b1; f_addr = 16'h10;
        @(posedge clk); #1;
        chk("rstwait.f_gnt", 32'(f_gnt), 32'h1);
        f_req = 1'b0;
        @(posedge clk); #1;
        chk("rstwait.in_wait_rvalid", 32'(f_rvalid), 32'h1);
        reset = 1'b1;
        #1;
        chk("rstwait.f_rvalid",   32'(f_rvalid),   32'h0);
        chk("rstwait.f_gnt0",     32'(f_gnt),      32'h0);
        chk("rstwait.mem_update", 32'(mem_update), 32'h0);
        chk("rstwait.f_rdata",    f_rdata,         32'h0);
        chk("rstwait.m_rdata",    m_rdata,         32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rstwait.no_rvalid%0d", k), 32'({f_rvalid, m_rvalid}), 32'h0);
        end
        f_req = 1'b1; f_addr = 16'h10;
        @(posedge clk); #1;
        chk("rstwait.relat_gnt",  32'(f_gnt),    32'h1);
        chk("rstwait.relat_addr", 32'(mem_addr), 32'h10);
        f_req = 1'b0;
        @(posedge clk); #1;
        chk("rstwait.relat_rvalid", 32'(f_rvalid), 32'h1);
        chk("rstwait.relat_rdata",  f_rdata,       DB);
        @(posedge clk); #1;

        // Both requesters held high: grant order depends on the starvation guard.
`ifdef MEM_ARB_STARVE_GUARD_EN
        n_exp = 6;
        expg[0] = 1'b1; expg[1] = 1'b1; expg[2] = 1'b0;
        expg[3] = 1'b1; expg[4] = 1'b1; expg[5] = 1'b0;
`else
        n_exp = 10;
        for (int i = 0; i < 10; i++) expg[i] = 1'b1;
`endif
        f_req = 1'b1; f_addr = 16'h10;
        m_req = 1'b1; m_rw = 1'b0; m_addr = 16'h44; m_wdata = '0;
        ng = 0;
        for (int c = 0; c < 80 && ng < n_exp; c++) begin
            @(posedge clk); #1;
            if (m_gnt) begin
                g[ng] = 1'b1; ng++;
            end else if (f_gnt) begin
                g[ng] = 1'b0; ng++;
            end
        end
        f_req = 1'b0; m_req = 1'b0;
        chk("starve.grant_count", ng, n_exp);
        for (int i = 0; i < 10; i++) begin
            if (i < int'(ng)) chk($sformatf("starve.grant%0d_is_m", i), 32'(g[i]), 32'(expg[i]));
        end
        repeat (3) @(posedge clk);
        #1;

        // MEM_LAT=3 instance: rvalid exactly three cycles after the issue cycle.
        m_req3 = 1'b1; m_rw3 = 1'b0; m_addr3 = 16'h44;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            if (m_gnt3) got = 1'b1;
        end
        chk("lat3.gnt_seen",   32'(got),         32'h1);
        chk("lat3.update",     32'(mem_update3), 32'h1);
        chk("lat3.addr",       32'(mem_addr3),   32'h44);
        m_req3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat3.rvalid_plus%0d", k), 32'(m_rvalid3), (k == 3) ? 32'h1 : 32'h0);
            if (k == 1) chk("lat3.update_off", 32'(mem_update3), 32'h0);
        end
        chk("lat3.rdata", m_rdata3, 32'h0BADCAFE);
        @(posedge clk); #1;
        chk("lat3.rvalid_end", 32'(m_rvalid3), 32'h0);
        chk("lat3.rdata_hold", m_rdata3,       32'h0BADCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
